// File: rtl/sqrt_result_reorder.sv
// In-order retirement buffer for out-of-order worker results.
// Optional same-cycle head bypass: define SQRT_REORDER_BYPASS_EN.
module sqrt_result_reorder #(
    parameter int DEPTH = 8,
    parameter int W = 32,
    localparam int TW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_req,
    output logic          alloc_gnt,
    output logic [TW-1:0] alloc_tag,
    input  logic          cmp_vld,
    input  logic [TW-1:0] cmp_tag,
    input  logic [W-1:0]  cmp_res,
    output logic          res_vld,
    output logic [W-1:0]  res,
    output logic [TW:0]   count,
    output logic          full,
    output logic          err
);

    typedef enum logic [1:0] {
        E_FREE,
        E_PEND,
        E_DONE
    } ent_st_t;

    ent_st_t        st_q   [DEPTH];
    ent_st_t        st_d   [DEPTH];
    logic [W-1:0]   data_q [DEPTH];
    logic [TW:0]    head_q;
    logic [TW:0]    tail_q;
    logic [TW-1:0]  head_idx;
    logic           retire_done;
    logic           cmp_legal;
    logic           bypass;
    logic           retire;
    logic           store;

    assign head_idx  = head_q[TW-1:0];
    assign alloc_tag = tail_q[TW-1:0];

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign full = (head_q[TW] != tail_q[TW])
               && (head_q[TW-1:0] == tail_q[TW-1:0]);

    assign alloc_gnt   = alloc_req && !full;
    assign retire_done = (st_q[head_idx] == E_DONE);
    assign cmp_legal   = cmp_vld && (st_q[cmp_tag] == E_PEND);

`ifdef SQRT_REORDER_BYPASS_EN
    // A DONE head makes a completion to head illegal, so the stored
    // entry keeps priority over the bypass without an explicit term.
    assign bypass = cmp_legal && (cmp_tag == head_idx);
`else
    assign bypass = 1'b0;
`endif

    assign retire = retire_done || bypass;
    assign store  = cmp_legal && !bypass;

    // Per-entry next state: allocate, complete, then retire.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i] = st_q[i];
        end
        if (alloc_gnt) begin
            st_d[alloc_tag] = E_PEND;
        end
        if (store) begin
            st_d[cmp_tag] = E_DONE;
        end
        if (retire) begin
            st_d[head_idx] = E_FREE;
        end
    end

    // Entry state register; reset discards every in-flight tag.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                st_q[i] <= E_FREE;
            end else begin
                st_q[i] <= st_d[i];
            end
        end
    end

    // Result storage; validity is tracked by the entry state alone.
    always_ff @(posedge clk) begin
        if (store) begin
            data_q[cmp_tag] <= cmp_res;
        end
    end

    // Pointers, occupancy and the registered result/error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count   <= '0;
            res_vld <= 1'b0;
            res     <= '0;
            err     <= 1'b0;
        end else begin
            if (alloc_gnt) begin
                tail_q <= tail_q + (TW+1)'(1);
            end
            if (retire) begin
                head_q <= head_q + (TW+1)'(1);
            end
            count   <= count + (TW+1)'(alloc_gnt)
                             - (TW+1)'(retire);
            res_vld <= retire;
            if (retire_done) begin
                res <= data_q[head_idx];
            end else if (bypass) begin
                res <= cmp_res;
            end
            err <= cmp_vld && !cmp_legal;
        end
    end

endmodule

// File: tb/tb_sqrt_result_reorder.sv
// Bench for sqrt_result_reorder: vector table, directed corners,
// and random traffic against a queue-based issue-order model.
module tb_sqrt_result_reorder;

    localparam int DEPTH = 8;
    localparam int W = 32;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [TW-1:0] alloc_tag;
    logic          cmp_vld;
    logic [TW-1:0] cmp_tag;
    logic [W-1:0]  cmp_res;
    logic          res_vld;
    logic [W-1:0]  res;
    logic [TW:0]   count;
    logic          full;
    logic          err;

    always #5 clk = ~clk;

    sqrt_result_reorder #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk),
        .rst(rst),
        .alloc_req(alloc_req),
        .alloc_gnt(alloc_gnt),
        .alloc_tag(alloc_tag),
        .cmp_vld(cmp_vld),
        .cmp_tag(cmp_tag),
        .cmp_res(cmp_res),
        .res_vld(res_vld),
        .res(res),
        .count(count),
        .full(full),
        .err(err)
    );

    typedef struct {
        bit          done;
        logic [31:0] val;
    } ment_t;

    typedef struct {
        bit          rst;
        bit          req;
        bit          cv;
        int          ct;
        logic [31:0] cr;
        bit          e_vld;
        logic [31:0] e_res;
        int          e_cnt;
        bit          e_err;
    } vec_t;

    ment_t         q[$];
    vec_t          tbl[$];
    int            hp;
    logic [31:0]   m_res;
    bit            m_vld;
    bit            m_err;
    bit            obs_gnt;
    logic [TW-1:0] obs_tag;
    int            checks;
    int            failures;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_req = 1'b0;
        cmp_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        hp = 0;
        m_res = '0;
        m_vld = 1'b0;
        m_err = 1'b0;
        chk("rst_res_vld", 64'(res_vld), 64'(0));
        chk("rst_res", 64'(res), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_tag", 64'(alloc_tag), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
    endtask

    // One clock of traffic; model predicts every output.
    task automatic cyc(input bit req, input bit cv, input int ct,
                       input logic [31:0] cr);
        bit    gnt;
        bit    legal;
        bit    ret;
        bit    byp;
        int    idx;
        ment_t e;
        alloc_req = req;
        cmp_vld = cv;
        cmp_tag = TW'(ct);
        cmp_res = cr;
        #1;
        gnt = req && (q.size() < DEPTH);
        obs_gnt = alloc_gnt;
        obs_tag = alloc_tag;
        chk("alloc_gnt", 64'(alloc_gnt), 64'(gnt));
        chk("alloc_tag", 64'(alloc_tag), 64'((hp + q.size()) % DEPTH));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        idx = (ct - hp + DEPTH) % DEPTH;
        legal = cv && (idx < q.size()) && !q[idx].done;
        ret = (q.size() > 0) && q[0].done;
        byp = 1'b0;
`ifdef SQRT_REORDER_BYPASS_EN
        byp = legal && (idx == 0);
`endif
        m_err = cv && !legal;
        m_vld = ret || byp;
        if (ret) m_res = q[0].val;
        else if (byp) m_res = cr;
        if (legal && !byp) begin
            e = q[idx];
            e.done = 1'b1;
            e.val = cr;
            q[idx] = e;
        end
        if (ret || byp) begin
            void'(q.pop_front());
            hp = (hp + 1) % DEPTH;
        end
        if (gnt) q.push_back('{1'b0, 32'h0});
        @(posedge clk);
        #1;
        chk("res_vld", 64'(res_vld), 64'(m_vld));
        chk("res", 64'(res), 64'(m_res));
        chk("count", 64'(count), 64'(q.size()));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic add(input bit r, input bit rq, input bit cv,
                       input int ct, input logic [31:0] cr,
                       input bit ev, input logic [31:0] er,
                       input int ec, input bit ee);
        tbl.push_back('{r, rq, cv, ct, cr, ev, er, ec, ee});
    endtask

    initial begin
        int nret;
        int allocs;
        int k;
        int tg;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        alloc_req = 1'b0;
        cmp_vld = 1'b0;
        cmp_tag = '0;
        cmp_res = '0;
        @(posedge clk);
        #1;

        // In-order, then reverse completion, then a FREE-tag completion.
        add(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0, 2, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0, 3, 0);
        add(0, 0, 1, 0, 32'h10, 0, 32'h0, 3, 0);
        add(0, 0, 1, 1, 32'h20, 1, 32'h10, 2, 0);
        add(0, 0, 1, 2, 32'h30, 1, 32'h20, 1, 0);
        add(0, 0, 0, 0, 0, 1, 32'h30, 0, 0);
        add(0, 0, 0, 0, 0, 0, 32'h30, 0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0, 2, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0, 3, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0, 4, 0);
        add(0, 0, 1, 3, 32'hA3, 0, 32'h0, 4, 0);
        add(0, 0, 1, 2, 32'hA2, 0, 32'h0, 4, 0);
        add(0, 0, 1, 1, 32'hA1, 0, 32'h0, 4, 0);
        add(0, 0, 1, 0, 32'hA0, 0, 32'h0, 4, 0);
        add(0, 0, 0, 0, 0, 1, 32'hA0, 3, 0);
        add(0, 0, 0, 0, 0, 1, 32'hA1, 2, 0);
        add(0, 0, 0, 0, 0, 1, 32'hA2, 1, 0);
        add(0, 0, 0, 0, 0, 1, 32'hA3, 0, 0);
        add(0, 0, 0, 0, 0, 0, 32'hA3, 0, 0);
        add(0, 0, 1, 5, 32'hDEAD, 0, 32'hA3, 0, 1);
        add(0, 0, 0, 0, 0, 0, 32'hA3, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            else cyc(tbl[i].req, tbl[i].cv, tbl[i].ct, tbl[i].cr);
`ifndef SQRT_REORDER_BYPASS_EN
            chk($sformatf("tbl%0d_vld", i), 64'(res_vld), 64'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_res", i), 64'(res), 64'(tbl[i].e_res));
            chk($sformatf("tbl%0d_cnt", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].e_err));
`endif
        end

        // Fill, refuse at full, retire/alloc collision, then wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0);
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_count", 64'(count), 64'(8));
        cyc(1, 1, 0, 32'h100);
        chk("ninth_gnt", 64'(obs_gnt), 64'(0));
`ifndef SQRT_REORDER_BYPASS_EN
        chk("coll_cnt_a", 64'(count), 64'(8));
        cyc(1, 0, 0, 0);
        chk("coll_gnt0", 64'(obs_gnt), 64'(0));
        chk("coll_cnt_b", 64'(count), 64'(7));
`endif
        cyc(1, 0, 0, 0);
        chk("wrap_gnt", 64'(obs_gnt), 64'(1));
        chk("wrap_tag0", 64'(obs_tag), 64'(0));
        chk("coll_cnt_c", 64'(count), 64'(8));
        nret = 1;
        allocs = 9;
        for (int c = 0; c < 80; c++) begin
            k = -1;
            for (int j = 0; j < q.size(); j++) begin
                if (!q[j].done) begin
                    k = j;
                    break;
                end
            end
            tg = (k < 0) ? 0 : (hp + k) % DEPTH;
            cyc(allocs < 20, k >= 0, tg, 32'h100 + nret + k);
            if (obs_gnt) begin
                chk("wrap_tag", 64'(obs_tag), 64'(allocs % DEPTH));
                allocs++;
            end
            if (m_vld) begin
                chk("wrap_order", 64'(res), 64'(32'h100 + nret));
                nret++;
            end
        end
        chk("wrap_allocs", 64'(allocs), 64'(20));
        chk("wrap_drained", 64'(count), 64'(0));

        // Completions to a FREE tag and to an already DONE tag.
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 5, 32'hBAD);
        chk("ill_free_err", 64'(err), 64'(1));
        cyc(0, 1, 0, 32'h55);
        chk("ill_ok_err", 64'(err), 64'(0));
        cyc(0, 1, 0, 32'hDEAD);
        chk("ill_done_err", 64'(err), 64'(1));
        chk("ill_done_res", 64'(res), 64'(32'h55));
        cyc(0, 0, 0, 0);
        chk("ill_pulse_end", 64'(err), 64'(0));
        chk("ill_res_keep", 64'(res), 64'(32'h55));

        // Reset with tags in flight; late completion is illegal.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        chk("mid_count", 64'(count), 64'(4));
        do_reset();
        cyc(0, 1, 2, 32'h77);
        chk("late_err", 64'(err), 64'(1));

        // Random traffic, biased toward completing live tags.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit rq;
            bit cv;
            rq = ($urandom_range(9) < 6);
            cv = ($urandom_range(9) < 7);
            if (q.size() > 0 && $urandom_range(3) != 0) begin
                k = $urandom_range(q.size() - 1);
                tg = (hp + k) % DEPTH;
            end else begin
                tg = $urandom_range(DEPTH - 1);
            end
            if ($urandom_range(299) == 0) do_reset();
            else cyc(rq, cv, tg, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqrt_result_reorder.md
Name: sqrt_result_reorder

Overview:
- Downstream collector for the multi-worker formula distributor.
- Workers finish out of order. This block allocates an in-order tag for every accepted argument triple, stores each tagged result as it completes, and retires results strictly in issue order.
- Result output is registered and has no backpressure.

Parameters:
- DEPTH, 8, number of reorder entries; must be a power of 2, minimum 2.
- W, 32, result data width.
- TW, $clog2(DEPTH), tag width; derived, not to be overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- alloc_req  input  1  distributor requests a tag for a new argument triple.
- alloc_gnt  output  1  combinational; equals alloc_req && !full. Tag is consumed when high.
- alloc_tag  output  TW  combinational; tag that will be granted this cycle (tail pointer).
- cmp_vld  input  1  a worker result is presented.
- cmp_tag  input  TW  tag of the presented result.
- cmp_res  input  W  result value.
- res_vld  output  1  registered; one in-order result is valid this cycle.
- res  output  W  registered; in-order result value.
- count  output  TW+1  registered; occupancy (PENDING + DONE entries).
- full  output  1  combinational; count == DEPTH.
- err  output  1  registered; one-cycle pulse on an illegal completion.

Behaviour:
- Reset (synchronous, rst sampled high at a clk edge):
  - head and tail pointers = 0; all entries FREE; count = 0.
  - res_vld = 0, res = 0, err = 0.
  - Any in-flight tags are discarded. Late completions arriving after reset get the illegal-completion handling below.
- Pointers:
  - head and tail are TW+1 bits; the low TW bits index entries.
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - Pointers wrap modulo 2*DEPTH.
- Per-entry state machine: FREE -> PENDING -> DONE -> FREE.
  - FREE -> PENDING: on alloc_gnt, for entry tail; tail increments.
  - PENDING -> DONE: on cmp_vld with cmp_tag naming this entry; cmp_res is stored.
  - DONE -> FREE: on retire, when the entry is at head; head increments.
- Retire:
  - At most one per cycle.
  - If entry[head] is DONE at a clk edge, that edge registers res = data[head] and res_vld = 1, and frees the entry.
  - Otherwise res_vld = 0 and res holds its last value.
- Latency: cmp_vld sampled in cycle k for the head entry -> res_vld high in cycle k+2.
- Throughput:
  - Back-to-back DONE entries retire on consecutive cycles.
  - A burst of DEPTH completions drains in DEPTH cycles.
- Illegal completion: cmp_vld on an entry that is FREE or already DONE.
  - Data is ignored; entry state is unchanged.
  - err pulses high in the next cycle.
- Simultaneous events:
  - alloc and retire in the same cycle: both happen; count is unchanged.
  - full is computed from the pre-edge state, so a slot freed by this cycle's retire is not granted until the next cycle.
  - alloc and cmp in the same cycle: independent; a completion to the tag being allocated in that same cycle is illegal.
  - cmp and retire to the same entry in the same cycle are impossible without the bypass (the entry is not yet DONE).
- count update: +1 on grant, -1 on retire, both applied at the same edge.
- alloc_req while full: alloc_gnt = 0, no state change; the requester must hold or stall.

Optional Feature:
- Macro: SQRT_REORDER_BYPASS_EN.
- Defined:
  - If cmp_vld && cmp_tag == head low bits && entry[head] is PENDING, the edge loads res = cmp_res and res_vld = 1 directly, and frees the entry.
  - Latency becomes k+1.
  - An entry[head] that is already DONE still has priority; in that case the bypass is not taken and the completion is stored normally.
- Undefined: no bypass; latency k+2 as above.

Test Plan:
- In-order completion: allocate tags 0,1,2; complete 0,1,2 with 32'h10,32'h20,32'h30 on consecutive cycles -> res 32'h10,32'h20,32'h30 on consecutive cycles; first res_vld 2 cycles after first cmp_vld (1 with bypass).
- Reverse completion: allocate 0..3; complete 3,2,1,0 with 32'hA3,A2,A1,A0 -> nothing retires until tag 0 completes, then 32'hA0,A1,A2,A3 on 4 consecutive cycles.
- Full and wrap:
  - Allocate 8 tags -> full = 1, alloc_gnt = 0 on a 9th request.
  - Complete and retire tag 0 -> next alloc_tag = 0 with tail MSB toggled.
  - Run 20 allocations total -> tags 0..7,0..7,0..3; retire order preserved.
- Simultaneous alloc/retire at count = 8: retire occurs, no grant that cycle, grant the following cycle; count goes 8 -> 7 -> 8.
- Illegal completion: cmp_vld on a FREE tag 5, and a second cmp on DONE tag 0 with 32'hDEAD -> err pulses 1 cycle each; tag 0 still retires its original value.
- Reset mid-operation: 4 pending entries, assert rst 1 cycle -> count = 0, res_vld = 0, res = 0, next alloc_tag = 0; a late cmp for old tag 2 raises err.
